apb_regbus_bridge: RTL
======================

Name: apb_regbus_bridge

Overview:
- Upstream stage for the generated register-file blocks. Terminates an APB3 completer port and drives the register file's custom bus: addr, chip_select, write_en, read_en, write_data, read_data, data_valid.
- Converts each APB transfer into one register-bus write pulse, or one held read strobe that completes on data_valid.
- Adds address-range checking and a read timeout, so a missing or stuck register file returns PSLVERR instead of hanging the APB bus.

Parameters:
- APB_ADDR_WIDTH, 12: PADDR width.
- ADDR_WIDTH, 8: register-bus addr width. PADDR bits above this must be zero.
- DATA_WIDTH, 32: data width on both sides.
- TIMEOUT_CYCLES, 15: RD-state cycles without data_valid before an error response. Must be ≥2.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  APB_ADDR_WIDTH  APB address.
- pwdata  in  DATA_WIDTH  APB write data.
- prdata  out  DATA_WIDTH  read data, registered.
- pready  out  1  single-cycle completion, registered.
- pslverr  out  1  error flag, valid only with pready.
- addr  out  ADDR_WIDTH  register-bus address.
- chip_select  out  1  register-bus select.
- write_en  out  1  register-bus write strobe.
- read_en  out  1  register-bus read strobe.
- write_data  out  DATA_WIDTH  register-bus write data.
- read_data  in  DATA_WIDTH  register-file read data. Combinational; valid only while read strobe is held.
- data_valid  in  1  register-file read acknowledge, asserted one cycle after a read strobe.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, timeout counter=0.
  - prdata, pready, pslverr, addr, chip_select, write_en, read_en, write_data all 0.
  - A reset mid-operation aborts the transfer immediately. No pready is issued.
- States: IDLE, WR, RD, DONE.
- IDLE:
  - Trigger: psel=1 & penable=0 (setup phase). On the trigger, latch paddr, pwdata and pwrite.
  - Out-of-range address (paddr[APB_ADDR_WIDTH-1:ADDR_WIDTH] ≠ 0): go to DONE with pslverr=1. No register-bus strobe is issued.
  - In-range write: go to WR. Set chip_select=1, write_en=1, addr, write_data.
  - In-range read: go to RD. Set chip_select=1, read_en=1, addr. Clear the timeout counter.
- WR:
  - Lasts exactly one cycle with the strobes high.
  - Then clear chip_select/write_en, set pready=1, pslverr=0, go to DONE.
  - Write latency: pready in the 2nd access cycle.
- RD:
  - Strobes stay high until an exit condition.
  - data_valid=1: capture prdata<=read_data, drop strobes, pready=1, pslverr=0, go to DONE. Nominal read latency: pready in the 3rd access cycle.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without data_valid: drop strobes, prdata<=0, pready=1, pslverr=1, go to DONE.
  - data_valid in the same cycle as timeout expiry: data wins, no error.
- DONE:
  - pready is high for exactly this one cycle, pslverr per the cause above.
  - Next cycle: pready=0, pslverr=0, state=IDLE.
- prdata holds its last value except on a read completion or timeout. Write responses leave it unchanged.
- data_valid outside RD is ignored.
- psel/penable deasserted mid-transfer (protocol violation): the bus operation still completes and the DONE pulse is still issued. No recovery logic.
- Back-to-back transfers: a new setup phase may occur in the cycle after pready and is accepted from IDLE with no bubble.
- addr and write_data hold their last values when idle. Only the strobes return to 0.

Decomposition:
- Package regbus_pkg:
  - state enum {IDLE, WR, RD, DONE}.
  - default widths ADDR_WIDTH/DATA_WIDTH.
  - timeout counter width $clog2(TIMEOUT_CYCLES).
- No sub-module. The FSM and counter stay inline (≈150 lines).

Test Plan:
- Write: APB write paddr=0x004, pwdata=0xDEADBEEF -> chip_select&write_en high exactly 1 cycle with addr=8'h04, write_data=0xDEADBEEF; pready=1, pslverr=0 in 2nd access cycle.
- Read: APB read paddr=0x004, model returns 0xDEADBEEF with data_valid one cycle after strobe -> read_en held 2 cycles, prdata=0xDEADBEEF, pready in 3rd access cycle, pslverr=0.
- Timeout: read with data_valid tied 0 -> strobes drop after 15 RD cycles; pready=1, pslverr=1, prdata=0. Repeat with data_valid arriving in cycle 15 -> no error.
- Range error: APB write paddr=0x104 -> no strobe ever asserted; pready next cycle with pslverr=1.
- Reset mid-read: assert rst_n=0 during RD -> next edge all outputs 0, no pready. Then a fresh read to 0x008 completes normally.
- Back-to-back: write 0x00C=0x12345678, then a read of 0x00C set up in the cycle after pready -> read returns 0x12345678 with no idle bubble.

Source files
------------

// File: rtl/regbus_pkg.sv
// Shared types and defaults for the APB to register-bus bridge.
// Holds the FSM state encoding and the timeout counter sizing helper.
package regbus_pkg;

  localparam int DEFAULT_APB_ADDR_WIDTH = 12;
  localparam int DEFAULT_ADDR_WIDTH     = 8;
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } bridge_state_e;

  // The counter only has to reach TIMEOUT_CYCLES-1.
  function automatic int timeout_cnt_width(input int timeout_cycles);
    return (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles);
  endfunction

endpackage

// File: rtl/apb_regbus_bridge.sv
// APB3 completer that turns each transfer into one register-bus write pulse
// or a held read strobe, with address range checking and a read timeout.
module apb_regbus_bridge
  import regbus_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = DEFAULT_APB_ADDR_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [ADDR_WIDTH-1:0]     addr,
  output logic                      chip_select,
  output logic                      write_en,
  output logic                      read_en,
  output logic [DATA_WIDTH-1:0]     write_data,
  input  logic [DATA_WIDTH-1:0]     read_data,
  input  logic                      data_valid
);

  // Handshakes: a transfer is accepted from IDLE on the APB setup phase
  // (psel=1, penable=0); pready is a one-cycle registered pulse in DONE and
  // pslverr is meaningful only alongside it. On the register bus a write is a
  // single-cycle chip_select+write_en pulse; a read holds chip_select+read_en
  // until data_valid (read_data sampled that same cycle) or the timeout.

  localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e          state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [DATA_WIDTH-1:0]  prdata_d;
  logic                   pready_d;
  logic                   pslverr_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic                   chip_select_d;
  logic                   write_en_d;
  logic                   read_en_d;
  logic [DATA_WIDTH-1:0]  write_data_d;
  logic                   setup_phase;
  logic                   out_of_range;

  assign setup_phase  = psel && !penable;
  assign out_of_range = (paddr >> ADDR_WIDTH) != '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      prdata      <= '0;
      pready      <= 1'b0;
      pslverr     <= 1'b0;
      addr        <= '0;
      chip_select <= 1'b0;
      write_en    <= 1'b0;
      read_en     <= 1'b0;
      write_data  <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      prdata      <= prdata_d;
      pready      <= pready_d;
      pslverr     <= pslverr_d;
      addr        <= addr_d;
      chip_select <= chip_select_d;
      write_en    <= write_en_d;
      read_en     <= read_en_d;
      write_data  <= write_data_d;
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    prdata_d      = prdata;
    pready_d      = 1'b0;
    pslverr_d     = 1'b0;
    addr_d        = addr;
    chip_select_d = chip_select;
    write_en_d    = write_en;
    read_en_d     = read_en;
    write_data_d  = write_data;

    case (state)
      IDLE: begin
        if (setup_phase) begin
          if (out_of_range) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else if (pwrite) begin
            state_d       = WR;
            chip_select_d = 1'b1;
            write_en_d    = 1'b1;
            addr_d        = paddr[ADDR_WIDTH-1:0];
            write_data_d  = pwdata;
          end else begin
            state_d       = RD;
            chip_select_d = 1'b1;
            read_en_d     = 1'b1;
            addr_d        = paddr[ADDR_WIDTH-1:0];
            cnt_d         = '0;
          end
        end
      end

      WR: begin
        state_d       = DONE;
        chip_select_d = 1'b0;
        write_en_d    = 1'b0;
        pready_d      = 1'b1;
      end

      RD: begin
        // data_valid is checked first so it beats a coincident timeout.
        if (data_valid) begin
          state_d       = DONE;
          chip_select_d = 1'b0;
          read_en_d     = 1'b0;
          prdata_d      = read_data;
          pready_d      = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_d       = DONE;
          chip_select_d = 1'b0;
          read_en_d     = 1'b0;
          prdata_d      = '0;
          pready_d      = 1'b1;
          pslverr_d     = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
